// File: rtl/lock_pkg.sv
// Shared definitions for the password lock sequencer.
// Contents:
//   state_e   - sequencer state encoding (IDLE..LOCKOUT, values visible on state_o)
//   DigitW    - width of one BCD digit
//   KeyMax    - largest key value accepted as a digit
//   bcd_mask  - mask selecting the low 'digits' BCD nibbles of a 32-bit word
package lock_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StEntry   = 3'd1,
    StCheck   = 3'd2,
    StOpen    = 3'd3,
    StSetPwd  = 3'd4,
    StLockout = 3'd5
  } state_e;

  localparam int unsigned DigitW = 4;
  localparam logic [3:0]  KeyMax = 4'd9;

  function automatic logic [31:0] bcd_mask(input int unsigned digits);
    if (digits >= 8) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << (digits * DigitW)) - 32'd1;
  endfunction

endpackage

// File: rtl/lock_down_timer.sv
// Loadable 8-bit down-counter used for the timed phases of the lock.
// Ports:
//   clk_i      - clock, rising edge
//   rst_i      - synchronous active-high reset (count -> 0)
//   load_i     - load load_val_i this cycle (wins over tick_i)
//   load_val_i - value to load
//   tick_i     - decrement enable; no effect once the count is 0
//   count_o    - current count
//   done_o     - one-cycle pulse: this tick takes the count from 1 to 0
module lock_down_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       tick_i,
  output logic [7:0] count_o,
  output logic       done_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (tick_i && (cnt_q != 8'd0)) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  // Combinational so the owner can change state on the same edge the count hits 0.
  assign done_o  = tick_i && !load_i && (cnt_q == 8'd1);
  assign count_o = cnt_q;

endmodule

// File: rtl/lock_seq_ctrl.sv
// Password lock sequencer: collects BCD digits, checks them against the stored
// password, drives the lock actuator and alarm, counts failures and enforces a
// lockout period. Timed phases run off the 1 Hz 'tick' strobe.
// Optional feature: define LOCK_IDLE_TIMEOUT_EN to abandon an entry (ENTRY or
// SETPWD) after IDLE_SEC ticks without an accepted digit; in ENTRY this counts
// as a failed attempt.
// Ports:
//   clk, rst         - clock and synchronous active-high reset
//   tick             - one-cycle time-base strobe
//   key_valid/key_val - digit strobe and value (10..15 ignored)
//   key_enter, key_clr, key_set - submit, discard, change-password strobes
//   unlocked, alarm  - registered actuator and alarm outputs
//   state_o          - current state encoding
//   digit_cnt, err_cnt - digits in current entry, consecutive failures
//   sec_left         - remaining ticks of OPEN/LOCKOUT, else 0
module lock_seq_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned MAX_ERR  = 3,
  parameter int unsigned OPEN_SEC = 5,
  parameter int unsigned LOCK_SEC = 10,
  parameter int unsigned IDLE_SEC = 8,
  parameter logic [31:0] INIT_PWD = 32'h0000_1234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       key_valid,
  input  logic [3:0] key_val,
  input  logic       key_enter,
  input  logic       key_clr,
  input  logic       key_set,
  output logic       unlocked,
  output logic       alarm,
  output logic [2:0] state_o,
  output logic [3:0] digit_cnt,
  output logic [3:0] err_cnt,
  output logic [7:0] sec_left
);

  localparam logic [31:0] CmpMask   = bcd_mask(DIGITS);
  localparam logic [3:0]  DigitsMax = 4'(DIGITS);

  state_e      state_q;
  logic [31:0] entry_q;
  logic [31:0] pwd_q;
  logic [3:0]  digit_cnt_q;
  logic [3:0]  err_cnt_q;
  logic        unlocked_q;
  logic        alarm_q;

  logic        digit_ok;
  logic        full;
  logic        match;
  logic [3:0]  err_inc;
  logic        fail_lock;
  logic        take_digit;
  logic        tmr_load;
  logic [7:0]  tmr_val;
  logic        tmr_done;
  logic        idle_done;

  // Key decode; kept apart from timer control so idle_done does not loop back.
  always_comb begin
    digit_ok   = key_valid && (key_val <= KeyMax) && (digit_cnt_q < DigitsMax);
    full       = (digit_cnt_q == DigitsMax);
    match      = full && ((entry_q & CmpMask) == (pwd_q & CmpMask));
    err_inc    = err_cnt_q + 4'd1;
    fail_lock  = (err_inc == 4'(MAX_ERR));
    take_digit = 1'b0;
    case (state_q)
      StIdle:   take_digit = digit_ok;
      StEntry:  take_digit = !key_clr && !key_enter && digit_ok;
      // A short key_enter is ignored, so a digit in the same cycle still counts.
      StSetPwd: take_digit = !key_clr && !(key_enter && full) && digit_ok;
      default:  take_digit = 1'b0;
    endcase
  end

  // Phase timer control: loaded leaving CHECK, cleared on key_set, and loaded
  // with the lockout period when an idle timeout trips the failure limit.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = 8'd0;
    case (state_q)
      StCheck: begin
        tmr_load = 1'b1;
        if (match) begin
          tmr_val = 8'(OPEN_SEC);
        end else if (fail_lock) begin
          tmr_val = 8'(LOCK_SEC);
        end
      end
      StOpen: begin
        if (key_set) begin
          tmr_load = 1'b1;
        end
      end
      StEntry: begin
        if (!key_clr && !key_enter && idle_done && fail_lock) begin
          tmr_load = 1'b1;
          tmr_val  = 8'(LOCK_SEC);
        end
      end
      default: ;
    endcase
  end

  lock_down_timer u_phase_tmr (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tick_i     (tick),
    .count_o    (sec_left),
    .done_o     (tmr_done)
  );

`ifdef LOCK_IDLE_TIMEOUT_EN
  logic       idle_load;
  logic [7:0] idle_count;

  // Reload on entering ENTRY (first digit) or SETPWD, and on every accepted digit.
  assign idle_load = take_digit || ((state_q == StOpen) && key_set);

  lock_down_timer u_idle_tmr (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (idle_load),
    .load_val_i (8'(IDLE_SEC)),
    .tick_i     (tick),
    .count_o    (idle_count),
    .done_o     (idle_done)
  );
`else
  assign idle_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      entry_q     <= 32'd0;
      pwd_q       <= INIT_PWD;
      digit_cnt_q <= 4'd0;
      err_cnt_q   <= 4'd0;
      unlocked_q  <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (take_digit) begin
            entry_q     <= {28'd0, key_val};
            digit_cnt_q <= 4'd1;
            state_q     <= StEntry;
          end
        end
        StEntry: begin
          if (key_clr) begin
            entry_q     <= 32'd0;
            digit_cnt_q <= 4'd0;
            state_q     <= StIdle;
          end else if (key_enter) begin
            state_q <= StCheck;
          end else if (idle_done) begin
            entry_q     <= 32'd0;
            digit_cnt_q <= 4'd0;
            err_cnt_q   <= err_inc;
            if (fail_lock) begin
              state_q <= StLockout;
              alarm_q <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end else if (take_digit) begin
            entry_q     <= {entry_q[31-DigitW:0], key_val};
            digit_cnt_q <= digit_cnt_q + 4'd1;
          end
        end
        StCheck: begin
          entry_q     <= 32'd0;
          digit_cnt_q <= 4'd0;
          if (match) begin
            err_cnt_q  <= 4'd0;
            state_q    <= StOpen;
            unlocked_q <= 1'b1;
          end else begin
            err_cnt_q <= err_inc;
            if (fail_lock) begin
              state_q <= StLockout;
              alarm_q <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StOpen: begin
          if (key_set) begin
            state_q <= StSetPwd;
          end else if (tmr_done) begin
            state_q    <= StIdle;
            unlocked_q <= 1'b0;
          end
        end
        StSetPwd: begin
          if (key_clr || (key_enter && full) || idle_done) begin
            if (!key_clr && key_enter && full) begin
              pwd_q <= entry_q;
            end
            entry_q     <= 32'd0;
            digit_cnt_q <= 4'd0;
            state_q     <= StIdle;
            unlocked_q  <= 1'b0;
          end else if (take_digit) begin
            entry_q     <= {entry_q[31-DigitW:0], key_val};
            digit_cnt_q <= digit_cnt_q + 4'd1;
          end
        end
        StLockout: begin
          if (tmr_done) begin
            state_q   <= StIdle;
            alarm_q   <= 1'b0;
            err_cnt_q <= 4'd0;
          end
        end
        default: begin
          // Unused encodings fall back to a clean IDLE.
          state_q     <= StIdle;
          entry_q     <= 32'd0;
          digit_cnt_q <= 4'd0;
          unlocked_q  <= 1'b0;
          alarm_q     <= 1'b0;
        end
      endcase
    end
  end

  assign unlocked  = unlocked_q;
  assign alarm     = alarm_q;
  assign state_o   = state_q;
  assign digit_cnt = digit_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/lock_seq_ctrl.md
Name: lock_seq_ctrl

Overview:
- Top-level sequencer for the password lock.
- Collects decimal key digits, compares them against a stored password, and drives the unlock and alarm outputs.
- Counts failed attempts and enforces a lockout period.
- Time-based phases are driven by internal tick-enabled down-counters; the `tick` strobe comes from the existing prescaler counter chain (1 Hz, one-cycle pulse).

Parameters:
- DIGITS, 4, number of password digits (1..8).
- MAX_ERR, 3, consecutive failures before lockout (1..15).
- OPEN_SEC, 5, ticks the lock stays open.
- LOCK_SEC, 10, ticks of alarm/lockout.
- IDLE_SEC, 8, inactivity ticks before an entry is abandoned (feature-gated).
- INIT_PWD, 32'h0000_1234, reset password; BCD, low nibble = last digit.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle time-base strobe
- key_valid  in  1  one-cycle strobe: key_val holds a digit
- key_val  in  4  digit 0..9; values 10..15 are ignored
- key_enter  in  1  one-cycle strobe: submit entry
- key_clr  in  1  one-cycle strobe: discard entry
- key_set  in  1  one-cycle strobe: change password (only in OPEN)
- unlocked  out  1  lock actuator
- alarm  out  1  high in LOCKOUT
- state_o  out  3  current state encoding
- digit_cnt  out  4  digits entered in current entry
- err_cnt  out  4  consecutive failures
- sec_left  out  8  remaining ticks of the active timed phase, else 0

Behaviour:
- Reset values: state IDLE; entry register 0; digit_cnt 0; err_cnt 0; password register = INIT_PWD; unlocked 0; alarm 0; sec_left 0.
- States: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, SETPWD=4, LOCKOUT=5. Encodings 6 and 7 are unreachable and return to IDLE.
- IDLE:
  - A valid digit goes to ENTRY.
  - That digit is shifted into the entry register and digit_cnt becomes 1 in the same cycle.
  - Other strobes are ignored.
- ENTRY:
  - A valid digit shifts left by 4 bits with the new digit in the low nibble; digit_cnt increments.
  - Once digit_cnt == DIGITS, further digits are ignored (no wrap).
  - key_clr: entry and digit_cnt go to 0, next state IDLE.
  - key_enter: next state CHECK.
- Priority within one cycle: key_clr > key_enter > key_valid.
- CHECK (exactly one cycle):
  - Match means digit_cnt == DIGITS and the entry equals the low DIGITS*4 bits of the password.
  - Match: err_cnt goes to 0, next state OPEN, sec_left loads OPEN_SEC.
  - Mismatch: err_cnt increments. If the new value equals MAX_ERR, next state LOCKOUT and sec_left loads LOCK_SEC; otherwise next state IDLE.
  - Entry and digit_cnt are cleared on leaving CHECK.
- OPEN:
  - unlocked=1, registered and asserted the cycle after CHECK.
  - Each tick decrements sec_left. On a tick with sec_left==1: sec_left goes to 0, next state IDLE, unlocked drops the next cycle.
  - key_set goes to SETPWD and sec_left goes to 0.
- SETPWD:
  - Unlocked stays high.
  - Digits are entered as in ENTRY.
  - key_enter with digit_cnt == DIGITS writes the entry into the password register and goes to IDLE.
  - key_enter with fewer digits is ignored.
  - key_clr aborts to IDLE with the password unchanged.
- LOCKOUT:
  - alarm=1; all key inputs are ignored.
  - Ticks decrement sec_left. On reaching 0: go to IDLE, alarm=0, err_cnt=0.
- tick and a key strobe arriving in the same cycle are both honoured.
- A tick in a state without an active timer has no effect.
- rst in any state, including mid-entry and mid-lockout, restores all reset values on the next clk edge; the changed password is lost.

Optional Feature:
- Macro: LOCK_IDLE_TIMEOUT_EN.
- Defined:
  - In ENTRY and SETPWD an inactivity counter loads IDLE_SEC on entry to the state and on every accepted digit.
  - Ticks decrement it. On reaching 0 the entry is cleared and the state goes to IDLE.
  - A timeout counts as a failure only in ENTRY. err_cnt increments and the MAX_ERR rule applies.
- Undefined: no inactivity counter; entry waits indefinitely.

Decomposition:
- Shared package lock_pkg holds:
  - state enumeration localparams (IDLE..LOCKOUT);
  - the BCD digit width (4);
  - the key-range limit (9).
- One sub-module, lock_down_timer:
  - loadable 8-bit down-counter: load, load value, tick enable;
  - outputs count and a one-cycle done pulse;
  - synchronous reset.
- lock_seq_ctrl instantiates it once for the OPEN/LOCKOUT phases, plus a second instance under LOCK_IDLE_TIMEOUT_EN.

Test Plan:
- Correct entry: keys 1,2,3,4 then enter → CHECK for 1 cycle; unlocked=1 the next cycle; sec_left=5; after 5 ticks back in IDLE with unlocked=0.
- Wrong entry 3 times (1,2,3,5 + enter): err_cnt 1→2→3; third attempt gives LOCKOUT, alarm=1, sec_left=10; digits ignored; after 10 ticks IDLE with err_cnt=0.
- Short entry: 1,2,3 + enter → mismatch, err_cnt=1. Extra digits 1,2,3,4,5 → digit_cnt stays 4 and entry is 1234 → match.
- Password change: unlock, key_set, 9,8,7,6 + enter → IDLE; 1,2,3,4 fails and 9,8,7,6 opens. Then rst → 1,2,3,4 opens again.
- Simultaneous key_clr + key_enter in ENTRY → IDLE, err_cnt unchanged. rst asserted mid-LOCKOUT → alarm=0 and err_cnt=0 on the next edge.
- Timeout, with LOCK_IDLE_TIMEOUT_EN defined: digit 1 then 8 ticks → IDLE and err_cnt=1.
